gmii_rx_latency_probe: RTL and testbench
========================================

Name: gmii_rx_latency_probe

Overview:
- Receive-side counterpart of the timestamped ARP probe transmitter. It sits on a PHY's GMII receive interface, in the PHY rx clock domain.
- Per frame it strips the preamble and SFD, checks the CRC-32 FCS, checks the frame length, and extracts the 0xDEADBEEF magic word and the 32-bit transmit timestamp.
- For each valid probe frame it publishes the one-way latency (units of timer ticks, 8 ns) plus saturating good/error frame counters for LED/7-seg display logic.

Parameters:
- MAGIC, 32'hDEADBEEF, magic word expected at payload offset MAGIC_OFS.
- MAGIC_OFS, 42, byte index after SFD (0 = first DA byte) of the magic MSB.
- TS_OFS, 46, byte index after SFD of the timestamp MSB.
- MIN_LEN, 64, minimum frame length in bytes after SFD, FCS included.
- MAX_PRE, 7, maximum number of 0x55 bytes accepted before SFD.

Ports:
- clock  in  1  PHY rx clock (125 MHz).
- reset  in  1  asynchronous, active-high reset.
- rx_dv  in  1  GMII receive data valid.
- rx_data  in  8  GMII receive data.
- timer  in  32  free-running timestamp counter, synchronous to clock.
- frame_done  out  1  one-cycle pulse at end of each delimited frame.
- frame_ok  out  1  status for last frame: CRC good and length >= MIN_LEN; held until next frame_done.
- crc_err  out  1  status for last frame: CRC residue mismatch; held.
- short_err  out  1  status for last frame: length < MIN_LEN; held.
- latency_valid  out  1  one-cycle pulse coincident with frame_done when latency is updated.
- latency  out  32  last measured latency; held between updates.
- good_cnt  out  16  saturating count of frame_ok frames.
- err_cnt  out  16  saturating count of frames with crc_err or short_err.

Behaviour:
- Reset: all outputs 0. State WAIT_IDLE, byte_cnt 0, CRC register 32'hFFFFFFFF.
- States:
  - WAIT_IDLE: go to IDLE on rx_dv=0. This avoids locking onto a frame already in progress at reset release.
  - IDLE: rx_dv=1 with rx_data=0x55 → PRE, pre_cnt=1. rx_dv=1 with any other byte → DROP.
  - PRE:
    - rx_dv=0 → IDLE, no frame_done.
    - 0x55 with pre_cnt<MAX_PRE → stay, pre_cnt+1.
    - 0xD5 → DATA; byte_cnt=0; CRC register reset to 32'hFFFFFFFF.
    - Any other byte, or 0x55 with pre_cnt=MAX_PRE → DROP.
  - DATA: each rx_dv=1 cycle feeds rx_data into the CRC.
    - CRC is Ethernet CRC-32: poly 0x04C11DB7, reflected, LSB-first per byte, init all ones.
    - byte_cnt increments by one, 12-bit, saturating at 4095.
    - The edge that samples rx_dv=0 ends the frame → IDLE.
  - DROP: wait for rx_dv=0 → IDLE. No frame_done and no counter update.
- Field capture in DATA:
  - Magic: byte_cnt MAGIC_OFS..+3 shift into magic_r, MSB first.
  - Timestamp: byte_cnt TS_OFS..+3 shift into tx_ts, MSB first.
  - At byte_cnt=TS_OFS, timer is sampled into rx_ts. Both stamps then reference the same byte, so latency excludes frame length.
- Frame end (edge sampling rx_dv=0 in DATA). The following are registered on that edge, visible the next cycle:
  - frame_done=1.
  - crc_err = (CRC register != 32'hC704DD7B). The residue is taken over all bytes including FCS.
  - short_err = (byte_cnt < MIN_LEN).
  - frame_ok = !crc_err && !short_err.
  - The good_cnt or err_cnt increment, saturating at 16'hFFFF.
- Latency update condition: frame_ok && byte_cnt >= TS_OFS+4 && magic_r==MAGIC.
  - When met: latency <= rx_ts − tx_ts modulo 2^32 and latency_valid=1.
  - Otherwise latency is held.
- Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient. frame_done of frame N may coincide with IDLE accepting the first preamble byte of frame N+1.
- Reset mid-frame: everything clears immediately. No frame_done for the aborted frame. Remaining bytes are ignored until rx_dv=0 (WAIT_IDLE).
- Latency for a single frame is not filtered; it is overwritten by each qualifying frame.

Test Plan:
- Valid 64-byte probe: 7×0x55, 0xD5, correct FCS, tx_ts=0x00001000, timer=0x00001020 at byte 46 → one frame_done with frame_ok=1, latency_valid=1, latency=0x20, good_cnt=1.
- Same frame with one FCS bit flipped → crc_err=1, frame_ok=0, err_cnt=1, latency stays 0x20, no latency_valid.
- Valid CRC, magic 0xDEADBEEE → frame_ok=1, good_cnt+1, latency_valid=0, latency unchanged.
- 40-byte frame with correct FCS → short_err=1, crc_err=0, err_cnt+1.
- Preamble faults: 8×0x55 then 0xD5, or 0x55,0x54 → no frame_done, counters unchanged; next valid frame after 1 idle cycle accepted normally.
- Wrap and reset: tx_ts=0xFFFFFFF0 with timer=0x00000010 → latency=0x20. Reset asserted at byte 20, released with rx_dv still high → no frame_done until a new frame follows an rx_dv=0 gap.

Source files
------------

// File: rtl/gmii_rx_latency_probe_if.sv
// GMII receive byte stream as seen by the probe: rx_dv qualifies rx_data every clock.
// The PHY drives it and the probe only listens.
interface gmii_rx_latency_probe_if;
    logic       rx_dv;
    logic [7:0] rx_data;

    modport master (output rx_dv, rx_data);
    modport slave  (input  rx_dv, rx_data);
endinterface

// File: rtl/gmii_rx_latency_probe.sv
// GMII rx probe: delimits frames, checks FCS/length, extracts magic + tx timestamp, reports latency.
// Status and counters are registered on the edge that samples rx_dv=0; there is no backpressure on the PHY stream.
module gmii_rx_latency_probe #(
    parameter logic [31:0] MAGIC     = 32'hDEADBEEF,
    parameter int          MAGIC_OFS = 42,
    parameter int          TS_OFS    = 46,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_PRE   = 7
) (
    input  logic                          clock,
    input  logic                          reset,
    gmii_rx_latency_probe_if.slave        gmii,
    input  logic [31:0]                   timer,
    output logic                          frame_done,
    output logic                          frame_ok,
    output logic                          crc_err,
    output logic                          short_err,
    output logic                          latency_valid,
    output logic [31:0]                   latency,
    output logic [15:0]                   good_cnt,
    output logic [15:0]                   err_cnt
);

    localparam int          PW          = $clog2(MAX_PRE + 1);
    localparam logic [PW-1:0] MAX_PRE_C = PW'(MAX_PRE);
    localparam logic [11:0] MAGIC_OFS_C = 12'(MAGIC_OFS);
    localparam logic [11:0] TS_OFS_C    = 12'(TS_OFS);
    localparam logic [11:0] MIN_LEN_C   = 12'(MIN_LEN);
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PRE,
        DATA,
        DROP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pre_cnt;
    logic [11:0]   byte_cnt;
    logic [31:0]   crc;
    logic [31:0]   magic_r;
    logic [31:0]   tx_ts;
    logic [31:0]   rx_ts;

    logic       dv;
    logic [7:0] dat;
    logic       crc_bad;
    logic       is_short;
    logic       good;
    logic       lat_hit;

    assign dv  = gmii.rx_dv;
    assign dat = gmii.rx_data;

    // MSB-first shift register fed LSB-first data bits: the bit-reverse of the
    // usual reflected Ethernet CRC, hence the C704DD7B residue.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    assign crc_bad  = (crc != CRC_RESIDUE);
    assign is_short = (byte_cnt < MIN_LEN_C);
    assign good     = !crc_bad && !is_short;
    assign lat_hit  = good && (byte_cnt >= TS_OFS_C + 12'd4) && (magic_r == MAGIC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (!dv) state_nxt = IDLE;
            IDLE: begin
                if (dv) state_nxt = (dat == 8'h55) ? PRE : DROP;
            end
            PRE: begin
                if (!dv)                                    state_nxt = IDLE;
                else if (dat == 8'hD5)                      state_nxt = DATA;
                else if (dat == 8'h55 && pre_cnt < MAX_PRE_C) state_nxt = PRE;
                else                                        state_nxt = DROP;
            end
            DATA:    if (!dv) state_nxt = IDLE;
            DROP:    if (!dv) state_nxt = IDLE;
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt       <= '0;
            byte_cnt      <= '0;
            crc           <= 32'hFFFFFFFF;
            magic_r       <= '0;
            tx_ts         <= '0;
            rx_ts         <= '0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            crc_err       <= 1'b0;
            short_err     <= 1'b0;
            latency_valid <= 1'b0;
            latency       <= '0;
            good_cnt      <= '0;
            err_cnt       <= '0;
        end else begin
            frame_done    <= 1'b0;
            latency_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (dv && dat == 8'h55) pre_cnt <= PW'(1);
                end
                PRE: begin
                    if (dv) begin
                        if (dat == 8'hD5) begin
                            byte_cnt <= '0;
                            crc      <= 32'hFFFFFFFF;
                            magic_r  <= '0;
                            tx_ts    <= '0;
                        end else if (dat == 8'h55 && pre_cnt < MAX_PRE_C) begin
                            pre_cnt <= pre_cnt + PW'(1);
                        end
                    end
                end
                DATA: begin
                    if (dv) begin
                        crc <= crc_step(crc, dat);
                        if (byte_cnt != 12'hFFF) byte_cnt <= byte_cnt + 12'd1;
                        if (byte_cnt >= MAGIC_OFS_C && byte_cnt < MAGIC_OFS_C + 12'd4)
                            magic_r <= {magic_r[23:0], dat};
                        if (byte_cnt >= TS_OFS_C && byte_cnt < TS_OFS_C + 12'd4)
                            tx_ts <= {tx_ts[23:0], dat};
                        // Both stamps reference byte TS_OFS, so frame length drops out.
                        if (byte_cnt == TS_OFS_C) rx_ts <= timer;
                    end else begin
                        frame_done <= 1'b1;
                        crc_err    <= crc_bad;
                        short_err  <= is_short;
                        frame_ok   <= good;
                        if (good) begin
                            if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                        end else begin
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end
                        if (lat_hit) begin
                            latency       <= rx_ts - tx_ts;
                            latency_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_latency_probe.sv
// Bench for gmii_rx_latency_probe: directed probe cases plus random frames against a frame-level model.
module tb_gmii_rx_latency_probe;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] timer;
    logic        frame_done, frame_ok, crc_err, short_err, latency_valid;
    logic [31:0] latency;
    logic [15:0] good_cnt, err_cnt;

    gmii_rx_latency_probe_if gmii ();

    gmii_rx_latency_probe dut (
        .clock         (clock),
        .reset         (reset),
        .gmii          (gmii),
        .timer         (timer),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .crc_err       (crc_err),
        .short_err     (short_err),
        .latency_valid (latency_valid),
        .latency       (latency),
        .good_cnt      (good_cnt),
        .err_cnt       (err_cnt)
    );

    always #4 clock = ~clock;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        ok;
        logic        ce;
        logic        se;
        logic        lv;
        logic [31:0] lat;
        logic [15:0] g;
        logic [15:0] e;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_done = 0;
    int          n_exp  = 0;
    logic [31:0] m_lat  = 0;
    int          m_good = 0;
    int          m_err  = 0;
    logic [31:0] tmr    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Standard reflected Ethernet CRC register (no final inversion).
    function automatic logic [31:0] crc_refl(input bq_t q, input int n);
        logic [31:0] c;
        logic [7:0]  v;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            v = q[k];
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ v[b]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic build(input int len, input logic [31:0] magic, input logic [31:0] txts,
                         input int flip, output bq_t f);
        logic [31:0] fcs;
        f = {};
        for (int k = 0; k < len - 4; k++) f.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) begin
            if (42 + k < len - 4) f[42 + k] = magic[31 - 8*k -: 8];
            if (46 + k < len - 4) f[46 + k] = txts[31 - 8*k -: 8];
        end
        fcs = ~crc_refl(f, f.size());
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        if (flip >= 0) f[flip / 8] = f[flip / 8] ^ (8'h01 << (flip % 8));
    endtask

    // Frame-level expectation: FCS residue, length, magic/timestamp fields from the byte list.
    task automatic predict(input bq_t d, input logic [31:0] rx_ts);
        int          n;
        logic        crc_ok, shrt, ok, lv;
        logic [31:0] mg, tx;
        n      = d.size();
        crc_ok = (crc_refl(d, n) == 32'hDEBB20E3);
        shrt   = ((n > 4095 ? 4095 : n) < 64);
        ok     = crc_ok && !shrt;
        mg     = (n >= 46) ? {d[42], d[43], d[44], d[45]} : 32'h0;
        tx     = (n >= 50) ? {d[46], d[47], d[48], d[49]} : 32'h0;
        lv     = ok && (n >= 50) && (mg == 32'hDEADBEEF);
        if (lv) m_lat = rx_ts - tx;
        if (ok) m_good = (m_good < 65535) ? m_good + 1 : 65535;
        else    m_err  = (m_err  < 65535) ? m_err  + 1 : 65535;
        exp_q.push_back('{ok, !crc_ok, shrt, lv, m_lat, 16'(m_good), 16'(m_err)});
        n_exp++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_ok"}, frame_ok, 0);
        chk({tag, "_crc_err"}, crc_err, 0);
        chk({tag, "_short_err"}, short_err, 0);
        chk({tag, "_latency_valid"}, latency_valid, 0);
        chk({tag, "_latency"}, latency, 0);
        chk({tag, "_good_cnt"}, good_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            gmii.rx_dv = 1'b0; gmii.rx_data = 8'h00;
            timer = tmr; tmr++;
        end
    endtask

    // Drives prefix+data, then gap idle cycles. fts forces the timer value seen with data byte 46.
    task automatic send(input bq_t pre, input bq_t d, input int gap, input bit fts,
                        input logic [31:0] fval, input bit expect_done, input int rst_at);
        logic [31:0] ts;
        int          np;
        ts = 0;
        np = pre.size();
        for (int k = 0; k < np + d.size(); k++) begin
            @(posedge clock); #1;
            if (k - np == 46) begin
                if (fts) tmr = fval;
                ts = tmr;
            end
            gmii.rx_dv   = 1'b1;
            gmii.rx_data = (k < np) ? pre[k] : d[k - np];
            timer = tmr; tmr++;
            reset = (k == rst_at);
            if (k == rst_at) begin
                @(negedge clock);
                check_zero("midrst");
                m_lat = 0; m_good = 0; m_err = 0;
            end
        end
        if (expect_done) predict(d, ts);
        repeat (gap) begin
            @(posedge clock); #1;
            gmii.rx_dv = 1'b0; gmii.rx_data = 8'h00; reset = 1'b0;
            timer = tmr; tmr++;
        end
    endtask

    always @(negedge clock) begin
        if (frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("pending_at_done", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("frame_ok", frame_ok, e.ok);
                chk("crc_err", crc_err, e.ce);
                chk("short_err", short_err, e.se);
                chk("latency_valid", latency_valid, e.lv);
                chk("latency", latency, e.lat);
                chk("good_cnt", good_cnt, e.g);
                chk("err_cnt", err_cnt, e.e);
            end
        end else if (latency_valid) begin
            chk("lv_without_done", latency_valid, frame_done);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    bq_t pre7, pre8, pre_bad, pre_r, f, f2;

    initial begin
        reset = 1'b1; gmii.rx_dv = 1'b0; gmii.rx_data = 8'h00; timer = 0;
        pre7 = {}; pre8 = {}; pre_bad = {8'h55, 8'h54};
        repeat (7) pre7.push_back(8'h55);
        pre7.push_back(8'hD5);
        repeat (8) pre8.push_back(8'h55);
        pre8.push_back(8'hD5);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        idle(3);

        // Basic probe: tx_ts 0x1000, timer 0x1020 at byte 46.
        build(64, 32'hDEADBEEF, 32'h00001000, -1, f);
        send(pre7, f, 1, 1, 32'h00001020, 1, -1);
        idle(2);
        chk("probe_latency", latency, 32'h20);
        chk("probe_good", good_cnt, 1);

        // One FCS bit flipped.
        f2 = f;
        f2[62] = f2[62] ^ 8'h10;
        send(pre7, f2, 1, 1, 32'h00002000, 1, -1);
        idle(2);
        chk("fcsflip_latency_held", latency, 32'h20);
        chk("fcsflip_err", err_cnt, 1);

        // Wrong magic, good CRC.
        build(64, 32'hDEADBEEE, 32'h00000100, -1, f);
        send(pre7, f, 1, 1, 32'h00000900, 1, -1);
        idle(2);
        chk("badmagic_latency_held", latency, 32'h20);
        chk("badmagic_good", good_cnt, 2);

        // Short frame.
        build(40, 32'hDEADBEEF, 32'h0, -1, f);
        send(pre7, f, 1, 0, 0, 1, -1);
        idle(2);
        chk("short_err_cnt", err_cnt, 2);

        // Preamble faults, then a valid frame after a single idle cycle.
        build(64, 32'hDEADBEEF, 32'h00000010, -1, f);
        send(pre8, f, 1, 1, 32'h00000050, 0, -1);
        send(pre_bad, f, 1, 1, 32'h00000050, 0, -1);
        send(pre7, f, 1, 1, 32'h00000050, 1, -1);
        idle(2);
        chk("after_prefault_latency", latency, 32'h40);

        // Timestamp wrap.
        build(64, 32'hDEADBEEF, 32'hFFFFFFF0, -1, f);
        send(pre7, f, 1, 1, 32'h00000010, 1, -1);
        idle(2);
        chk("wrap_latency", latency, 32'h20);

        // Reset at data byte 20 with rx_dv held high, then a fresh frame.
        build(64, 32'hDEADBEEF, 32'h00000000, -1, f);
        send(pre7, f, 2, 1, 32'h00000005, 0, 8 + 20);
        build(70, 32'hDEADBEEF, 32'h00000300, -1, f);
        send(pre7, f, 1, 1, 32'h00000333, 1, -1);
        idle(2);
        chk("postrst_good", good_cnt, 1);
        chk("postrst_err", err_cnt, 0);
        chk("postrst_latency", latency, 32'h33);

        // Random frames, back-to-back with short gaps.
        for (int t = 0; t < 40; t++) begin
            int          len, np, flip;
            logic [31:0] mg;
            len  = $urandom_range(30, 110);
            np   = $urandom_range(1, 7);
            mg   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hDEADBEEF;
            flip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len * 8 - 1) : -1;
            build(len, mg, 32'($urandom), flip, f);
            pre_r = {};
            repeat (np) pre_r.push_back(8'h55);
            pre_r.push_back(8'hD5);
            send(pre_r, f, $urandom_range(1, 3), $urandom_range(0, 1), 32'($urandom), 1, -1);
        end
        idle(4);

        chk("pending_at_end", 32'(exp_q.size()), 0);
        chk("done_count", 32'(n_done), 32'(n_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
